// File: rtl/adc_spi_scanner_if.sv
// Control and sample bus between the ADC scanner and its consumer.
// The master side issues scan requests; the slave side returns channel-tagged samples.
interface adc_spi_scanner_if #(
    parameter int NUM_CH     = 8,
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 3
);
    logic                  start;
    logic                  stop;
    logic                  mode;
    logic [NUM_CH-1:0]     ch_mask;
    logic                  busy;
    logic                  sample_valid;
    logic [DATA_WIDTH-1:0] sample_data;
    logic [ADDR_WIDTH-1:0] sample_ch;
    logic                  scan_done;

    modport master (
        output start, stop, mode, ch_mask,
        input  busy, sample_valid, sample_data, sample_ch, scan_done
    );

    modport slave (
        input  start, stop, mode, ch_mask,
        output busy, sample_valid, sample_data, sample_ch, scan_done
    );
endinterface

// File: rtl/adc_spi_scanner.sv
// Multi-channel SPI ADC scanner (ADC128S022-style). Scans an enabled-channel mask,
// single pass or continuous, compensating for the converter's one-frame address pipeline.
module adc_spi_scanner #(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 3,
    parameter int NUM_CH     = 8,
    parameter int FRAME_BITS = 16,
    parameter int ADDR_POS   = 2,
    parameter int HALF_DIV   = 4,
    parameter int CS_GAP     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    adc_spi_scanner_if.slave bus,
    output logic             adc_cs_n,
    output logic             adc_sclk,
    output logic             adc_din,
    input  logic             adc_dout
);
    localparam int CNT_MAX = (HALF_DIV > CS_GAP) ? HALF_DIV : CS_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int BIT_W   = $clog2(FRAME_BITS);

    typedef enum logic [1:0] {IDLE, LEAD, SHIFT, GAP} state_t;

    state_t                state_reg, state_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic [BIT_W-1:0]      bit_reg, bit_next;
    logic [NUM_CH-1:0]     mask_reg, mask_next;
    logic                  mode_reg, mode_next;
    logic [ADDR_WIDTH-1:0] tx_ch_reg, tx_ch_next;
    logic [ADDR_WIDTH-1:0] rx_ch_reg, rx_ch_next;
    logic                  primed_reg, primed_next;
    logic                  stop_reg, stop_next;
    logic                  finish_reg, finish_next;
    logic                  pend_reg, pend_next;
    logic [DATA_WIDTH-1:0] rx_reg, rx_next;
    logic                  cs_n_reg, cs_n_next;
    logic                  sclk_reg, sclk_next;
    logic                  din_reg, din_next;
    logic                  valid_reg, valid_next;
    logic                  done_reg, done_next;
    logic [DATA_WIDTH-1:0] data_reg, data_next;
    logic [ADDR_WIDTH-1:0] sch_reg, sch_next;
    logic [FRAME_BITS-1:0] frame_din;
    logic [ADDR_WIDTH-1:0] high_ch;

    // Next enabled channel after cur, wrapping; searching after NUM_CH-1 yields the lowest.
    function automatic logic [ADDR_WIDTH-1:0] next_ch(input logic [ADDR_WIDTH-1:0] cur,
                                                      input logic [NUM_CH-1:0] m);
        logic [ADDR_WIDTH-1:0] r;
        logic [NUM_CH-1:0]     s;
        logic                  found;
        int                    c;
        r     = cur;
        found = 1'b0;
        for (int k = 1; k <= NUM_CH; k++) begin
            c = (int'(cur) + k) % NUM_CH;
            s = m >> c;
            if (!found && s[0]) begin
                r     = ADDR_WIDTH'(c);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] top_ch(input logic [NUM_CH-1:0] m);
        logic [ADDR_WIDTH-1:0] h;
        logic [NUM_CH-1:0]     s;
        h = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            s = m >> k;
            if (s[0]) h = ADDR_WIDTH'(k);
        end
        return h;
    endfunction

    // Per-bit din pattern of one frame: address MSB first at ADDR_POS, zeros elsewhere.
    generate
        for (genvar gi = 0; gi < FRAME_BITS; gi++) begin : g_din
            if (gi >= ADDR_POS && gi < ADDR_POS + ADDR_WIDTH) begin : g_addr
                assign frame_din[gi] = tx_ch_reg[ADDR_WIDTH-1-(gi-ADDR_POS)];
            end else begin : g_zero
                assign frame_din[gi] = 1'b0;
            end
        end
    endgenerate

    assign high_ch          = top_ch(mask_reg);
    assign bus.busy         = (state_reg != IDLE);
    assign bus.sample_valid = valid_reg;
    assign bus.sample_data  = data_reg;
    assign bus.sample_ch    = sch_reg;
    assign bus.scan_done    = done_reg;
    assign adc_cs_n         = cs_n_reg;
    assign adc_sclk         = sclk_reg;
    assign adc_din          = din_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            bit_reg    <= '0;
            mask_reg   <= '0;
            mode_reg   <= 1'b0;
            tx_ch_reg  <= '0;
            rx_ch_reg  <= '0;
            primed_reg <= 1'b0;
            stop_reg   <= 1'b0;
            finish_reg <= 1'b0;
            pend_reg   <= 1'b0;
            rx_reg     <= '0;
            cs_n_reg   <= 1'b1;
            sclk_reg   <= 1'b1;
            din_reg    <= 1'b0;
            valid_reg  <= 1'b0;
            done_reg   <= 1'b0;
            data_reg   <= '0;
            sch_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            bit_reg    <= bit_next;
            mask_reg   <= mask_next;
            mode_reg   <= mode_next;
            tx_ch_reg  <= tx_ch_next;
            rx_ch_reg  <= rx_ch_next;
            primed_reg <= primed_next;
            stop_reg   <= stop_next;
            finish_reg <= finish_next;
            pend_reg   <= pend_next;
            rx_reg     <= rx_next;
            cs_n_reg   <= cs_n_next;
            sclk_reg   <= sclk_next;
            din_reg    <= din_next;
            valid_reg  <= valid_next;
            done_reg   <= done_next;
            data_reg   <= data_next;
            sch_reg    <= sch_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        bit_next    = bit_reg;
        mask_next   = mask_reg;
        mode_next   = mode_reg;
        tx_ch_next  = tx_ch_reg;
        rx_ch_next  = rx_ch_reg;
        primed_next = primed_reg;
        stop_next   = stop_reg | (bus.stop & (state_reg != IDLE));
        finish_next = finish_reg;
        pend_next   = 1'b0;
        rx_next     = rx_reg;
        cs_n_next   = cs_n_reg;
        sclk_next   = sclk_reg;
        din_next    = din_reg;
        valid_next  = 1'b0;
        done_next   = 1'b0;
        data_next   = data_reg;
        sch_next    = sch_reg;

        // Sample is published one clk after the final bit was captured.
        if (pend_reg) begin
            valid_next = 1'b1;
            data_next  = rx_reg;
            sch_next   = rx_ch_reg;
            done_next  = (rx_ch_reg == high_ch);
        end

        case (state_reg)
            IDLE: begin
                stop_next = 1'b0;
                if (bus.start && (bus.ch_mask != '0)) begin
                    state_next  = LEAD;
                    mask_next   = bus.ch_mask;
                    mode_next   = bus.mode;
                    tx_ch_next  = next_ch(ADDR_WIDTH'(NUM_CH - 1), bus.ch_mask);
                    primed_next = 1'b0;
                    finish_next = 1'b0;
                    cnt_next    = '0;
                    cs_n_next   = 1'b0;
                end
            end
            LEAD: begin
                if (stop_next) begin
                    state_next = GAP;
                    cnt_next   = '0;
                    cs_n_next  = 1'b1;
                end else if (cnt_reg == CNT_W'(HALF_DIV - 1)) begin
                    state_next = SHIFT;
                    cnt_next   = '0;
                    bit_next   = '0;
                    sclk_next  = 1'b0;
                    din_next   = frame_din[0];
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            SHIFT: begin
                if (cnt_reg != CNT_W'(HALF_DIV - 1)) begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end else begin
                    cnt_next = '0;
                    if (!sclk_reg) begin
                        sclk_next = 1'b1;
                        rx_next   = DATA_WIDTH'({rx_reg, adc_dout});
                        pend_next = (bit_reg == BIT_W'(FRAME_BITS - 1)) && primed_reg;
                    end else if (bit_reg == BIT_W'(FRAME_BITS - 1)) begin
                        // Frame complete: the channel just sent is the one returned next frame.
                        state_next  = GAP;
                        cs_n_next   = 1'b1;
                        bit_next    = '0;
                        rx_ch_next  = tx_ch_reg;
                        tx_ch_next  = next_ch(tx_ch_reg, mask_reg);
                        primed_next = 1'b1;
                        finish_next = !mode_reg && primed_reg && (rx_ch_reg == high_ch);
                    end else begin
                        bit_next  = bit_reg + BIT_W'(1);
                        sclk_next = 1'b0;
                        din_next  = frame_din[bit_reg + BIT_W'(1)];
                    end
                end
            end
            GAP: begin
                if (cnt_reg == CNT_W'(CS_GAP - 1)) begin
                    cnt_next = '0;
                    if (finish_reg || stop_next) begin
                        state_next = IDLE;
                    end else begin
                        state_next = LEAD;
                        cs_n_next  = 1'b0;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_adc_spi_scanner.sv
// Scoreboard bench for adc_spi_scanner: two instances (HALF_DIV 4 and 2), each with
// a pipelined ADC model returning 12'h100 + address of the previous frame.
module tb_adc_spi_scanner;
    localparam int CLK_PER = 10;

    typedef struct packed {
        logic [2:0]  ch;
        logic [11:0] data;
        logic        done;
    } smp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #(CLK_PER/2) clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    adc_spi_scanner_if #(.NUM_CH(8), .DATA_WIDTH(12), .ADDR_WIDTH(3)) bus4 ();
    adc_spi_scanner_if #(.NUM_CH(8), .DATA_WIDTH(12), .ADDR_WIDTH(3)) bus2 ();
    logic cs_n4, sclk4, din4, dout4;
    logic cs_n2, sclk2, din2, dout2;

    adc_spi_scanner #(.HALF_DIV(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(bus4.slave),
        .adc_cs_n(cs_n4), .adc_sclk(sclk4), .adc_din(din4), .adc_dout(dout4));
    adc_spi_scanner #(.HALF_DIV(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2.slave),
        .adc_cs_n(cs_n2), .adc_sclk(sclk2), .adc_din(din2), .adc_dout(dout2));

    smp_t q4[$];
    smp_t q2[$];
    logic [2:0] addr_log4[$];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic smp_t mk(input int ch, input logic done);
        smp_t r;
        r.ch   = 3'(ch);
        r.data = 12'h100 + 12'(ch);
        r.done = done;
        return r;
    endfunction

    // ADC model, instance 4: data for the previous frame's address, shifted out on SCLK falls.
    logic [2:0]  ash4 = '0, prev4 = '0;
    logic [15:0] sh4 = '0;
    int falls4 = 0, rises4 = 0, sf4 = 0;
    longint last_rise4 = 0;
    always @(negedge cs_n4) begin
        falls4++; rises4 = 0; sf4 = 0;
        sh4 = {4'h0, 12'h100 + 12'(prev4)};
        dout4 = sh4[15];
    end
    always @(negedge sclk4) if (!cs_n4) begin
        if (sf4 > 0) sh4 = sh4 << 1;
        dout4 = sh4[15];
        sf4++;
    end
    always @(posedge sclk4) if (!cs_n4) begin
        if (rises4 >= 2 && rises4 < 5) ash4 = {ash4[1:0], din4};
        if (rises4 > 0) chk("sclk_period4", 32'($time - last_rise4), 32'(8*CLK_PER));
        last_rise4 = $time;
        rises4++;
    end
    always @(posedge cs_n4) begin
        prev4 = ash4;
        addr_log4.push_back(ash4);
    end

    // ADC model, instance 2, with per-frame edge count.
    logic [2:0]  ash2 = '0, prev2 = '0;
    logic [15:0] sh2 = '0;
    int falls2 = 0, rises2 = 0, sf2 = 0;
    logic in_frame2 = 1'b0;
    always @(negedge cs_n2) begin
        falls2++; rises2 = 0; sf2 = 0; in_frame2 = 1'b1;
        sh2 = {4'h0, 12'h100 + 12'(prev2)};
        dout2 = sh2[15];
    end
    always @(negedge sclk2) if (!cs_n2) begin
        if (sf2 > 0) sh2 = sh2 << 1;
        dout2 = sh2[15];
        sf2++;
    end
    always @(posedge sclk2) if (!cs_n2) begin
        if (rises2 >= 2 && rises2 < 5) ash2 = {ash2[1:0], din2};
        rises2++;
    end
    always @(posedge cs_n2) begin
        prev2 = ash2;
        if (in_frame2) chk("rises_per_frame2", 32'(rises2), 32'd16);
        in_frame2 = 1'b0;
    end

    // Monitors: pop and compare on every sample strobe; frame-shape checks on instance 2.
    logic cs_prev2 = 1'b1, sclk_prev2 = 1'b1, din_prev2 = 1'b0, first2 = 1'b1;
    int gap2 = 0, din_viol2 = 0;
    always @(negedge clk) begin
        smp_t e;
        if (rst_n && bus4.sample_valid) begin
            $display("dut4 sample ch=%0d data=%03h done=%0b", bus4.sample_ch, bus4.sample_data, bus4.scan_done);
            if (q4.size() == 0) chk("unexpected_sample4", 32'd1, 32'd0);
            else begin
                e = q4.pop_front();
                chk("sample4", {16'd0, bus4.sample_ch, bus4.sample_data, bus4.scan_done}, {16'd0, e});
            end
        end
        if (rst_n && bus4.scan_done && !bus4.sample_valid) chk("lone_done4", 32'd1, 32'd0);
        if (rst_n && bus2.sample_valid) begin
            $display("dut2 sample ch=%0d data=%03h done=%0b", bus2.sample_ch, bus2.sample_data, bus2.scan_done);
            if (q2.size() == 0) chk("unexpected_sample2", 32'd1, 32'd0);
            else begin
                e = q2.pop_front();
                chk("sample2", {16'd0, bus2.sample_ch, bus2.sample_data, bus2.scan_done}, {16'd0, e});
            end
        end
        if (!bus2.busy) first2 = 1'b1;
        if (!cs_n2 && cs_prev2) begin
            if (!first2) chk("cs_gap2", 32'(gap2), 32'd4);
            first2 = 1'b0;
            gap2 = 0;
        end else if (cs_n2) gap2++;
        if (din2 != din_prev2 && !(sclk_prev2 && !sclk2)) din_viol2++;
        cs_prev2 = cs_n2; sclk_prev2 = sclk2; din_prev2 = din2;
    end

    task automatic start4(input logic m, input logic [7:0] mask);
        @(negedge clk);
        bus4.start = 1'b1; bus4.mode = m; bus4.ch_mask = mask;
        @(negedge clk);
        bus4.start = 1'b0;
    endtask

    task automatic stop4();
        @(negedge clk); bus4.stop = 1'b1;
        @(negedge clk); bus4.stop = 1'b0;
    endtask

    task automatic wait_idle4(input string nm);
        int n = 0;
        while (bus4.busy && n < 6000) begin @(negedge clk); n++; end
        if (bus4.busy) chk({"timeout_", nm}, 32'd1, 32'd0);
    endtask

    task automatic wait_falls4(input int target, input string nm);
        int n = 0;
        while (falls4 < target && n < 6000) begin @(negedge clk); n++; end
        if (falls4 < target) chk({"timeout_", nm}, 32'(falls4), 32'(target));
    endtask

    task automatic chk_reset4(input string nm);
        chk({nm, "_cs_n"}, 32'(cs_n4), 32'd1);
        chk({nm, "_sclk"}, 32'(sclk4), 32'd1);
        chk({nm, "_din"}, 32'(din4), 32'd0);
        chk({nm, "_busy"}, 32'(bus4.busy), 32'd0);
        chk({nm, "_valid"}, 32'(bus4.sample_valid), 32'd0);
        chk({nm, "_done"}, 32'(bus4.scan_done), 32'd0);
        chk({nm, "_data"}, 32'(bus4.sample_data), 32'd0);
        chk({nm, "_ch"}, 32'(bus4.sample_ch), 32'd0);
    endtask

    initial begin
        int base, viol, n;
        bus4.start = 0; bus4.stop = 0; bus4.mode = 0; bus4.ch_mask = '0;
        bus2.start = 0; bus2.stop = 0; bus2.mode = 0; bus2.ch_mask = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset4("reset");

        // Single pass over ch0, ch2; a second start mid-scan must be ignored.
        addr_log4.delete();
        q4.push_back(mk(0, 1'b0)); q4.push_back(mk(2, 1'b1));
        base = falls4;
        start4(1'b0, 8'h05);
        repeat (20) @(negedge clk);
        start4(1'b1, 8'hFF);
        wait_idle4("single05");
        repeat (20) @(negedge clk);
        chk("single05_frames", 32'(falls4 - base), 32'd3);
        chk("single05_addr_count", 32'(addr_log4.size()), 32'd3);
        if (addr_log4.size() == 3) begin
            chk("single05_addr0", 32'(addr_log4[0]), 32'd0);
            chk("single05_addr1", 32'(addr_log4[1]), 32'd2);
            chk("single05_addr2", 32'(addr_log4[2]), 32'd0);
        end
        chk("single05_pending", 32'(q4.size()), 32'd0);
        chk("single05_cs_idle", 32'(cs_n4), 32'd1);

        // Empty mask: start is ignored.
        start4(1'b0, 8'h00);
        viol = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus4.busy || !cs_n4 || bus4.sample_valid || bus4.scan_done) viol++;
        end
        chk("mask0_activity", 32'(viol), 32'd0);

        // Continuous on ch7, stop during frame 2.
        q4.push_back(mk(7, 1'b1)); q4.push_back(mk(7, 1'b1));
        base = falls4;
        start4(1'b1, 8'h80);
        wait_falls4(base + 3, "cont80");
        repeat (10) @(negedge clk);
        stop4();
        wait_idle4("cont80");
        repeat (20) @(negedge clk);
        chk("cont80_frames", 32'(falls4 - base), 32'd3);
        chk("cont80_pending", 32'(q4.size()), 32'd0);
        chk("cont80_cs_n", 32'(cs_n4), 32'd1);
        chk("cont80_sclk", 32'(sclk4), 32'd1);

        // Continuous over all channels, three passes.
        for (int p = 0; p < 24; p++) q4.push_back(mk(p % 8, (p % 8) == 7));
        base = falls4;
        start4(1'b1, 8'hFF);
        wait_falls4(base + 25, "contFF");
        repeat (10) @(negedge clk);
        stop4();
        wait_idle4("contFF");
        repeat (20) @(negedge clk);
        chk("contFF_frames", 32'(falls4 - base), 32'd25);
        chk("contFF_pending", 32'(q4.size()), 32'd0);

        // Reset in the middle of a frame, then a fresh single-channel scan.
        q4.push_back(mk(0, 1'b0));
        base = falls4;
        start4(1'b1, 8'hFF);
        wait_falls4(base + 3, "reset_mid");
        n = 0;
        while (rises4 < 7 && n < 500) begin @(negedge clk); n++; end
        chk("reset_mid_reached_bit7", 32'(rises4 >= 7), 32'd1);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset4("reset_mid");
        chk("reset_mid_pending", 32'(q4.size()), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        q4.push_back(mk(2, 1'b1));
        base = falls4;
        start4(1'b0, 8'h04);
        wait_idle4("after_reset");
        repeat (20) @(negedge clk);
        chk("after_reset_frames", 32'(falls4 - base), 32'd2);
        chk("after_reset_pending", 32'(q4.size()), 32'd0);

        // Frame-shape check on the HALF_DIV=2 instance.
        q2.push_back(mk(0, 1'b0)); q2.push_back(mk(1, 1'b1));
        base = falls2;
        @(negedge clk);
        bus2.start = 1'b1; bus2.mode = 1'b0; bus2.ch_mask = 8'h03;
        @(negedge clk);
        bus2.start = 1'b0;
        n = 0;
        while (bus2.busy && n < 3000) begin @(negedge clk); n++; end
        if (bus2.busy) chk("timeout_hd2", 32'd1, 32'd0);
        repeat (20) @(negedge clk);
        chk("hd2_frames", 32'(falls2 - base), 32'd3);
        chk("hd2_pending", 32'(q2.size()), 32'd0);
        chk("hd2_din_only_on_fall", 32'(din_viol2), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
